itch_book_arbiter: RTL and testbench

- Merges the three decoded ITCH message streams (add, delete, execute) from the ITCH parser into one ordered command stream for the order-book engine.
- Input streams are valid-only pulses with no backpressure; the book side uses a valid/ready handshake.
- Per-source FIFOs absorb book stalls. An arrival-sequence stamp guarantees output order equals arrival order across sources.
- Overflow is detected per source and reported.

---
 rtl/itch_book_pkg.sv | 28 ++
 rtl/itch_book_arbiter_if.sv | 46 ++++
 rtl/itch_arb_fifo.sv | 44 ++++
 rtl/itch_book_arbiter.sv | 125 ++++++++++++
 tb/tb_itch_book_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/itch_book_pkg.sv
// rtl/itch_book_pkg.sv - shared command types and stamp age compare for the ITCH book arbiter
package itch_book_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_DEL  = 2'd1,
        OP_EXEC = 2'd2
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [15:0] locate;
        logic [63:0] refNum;
        logic        buySell;
        logic [31:0] shares;
        logic [31:0] price;
    } book_cmd_t;

    localparam int CMD_W = $bits(book_cmd_t);

    // Wrapping age test: a is older than b when (a-b) mod 2^seq_w has its MSB set.
    function automatic logic is_older(input logic [31:0] a, input logic [31:0] b, input int seq_w);
        logic [31:0] diff;
        diff = (a - b) >> (seq_w - 1);
        return diff[0];
    endfunction

endpackage

// File: rtl/itch_book_arbiter_if.sv
// rtl/itch_book_arbiter_if.sv - parser-side message strobes and book-side command handshake
interface itch_book_arbiter_if
    import itch_book_pkg::*;
#(
    parameter int DROP_W = 16
);
    logic              addValid;
    logic [15:0]       addLocate;
    logic [63:0]       addRefNum;
    logic              addBuySell;
    logic [31:0]       addShares;
    logic [31:0]       addPrice;
    logic              delValid;
    logic [15:0]       delLocate;
    logic [63:0]       delRefNum;
    logic              execValid;
    logic [15:0]       execLocate;
    logic [63:0]       execRefNum;
    logic              bookReady;
    logic              bookValid;
    op_t               bookOp;
    logic [15:0]       bookLocate;
    logic [63:0]       bookRefNum;
    logic              bookBuySell;
    logic [31:0]       bookShares;
    logic [31:0]       bookPrice;
    logic              clrOvf;
    logic [2:0]        ovfFlags;
    logic [DROP_W-1:0] dropCnt;

    modport master (
        output addValid, addLocate, addRefNum, addBuySell, addShares, addPrice,
        output delValid, delLocate, delRefNum, execValid, execLocate, execRefNum,
        output bookReady, clrOvf,
        input  bookValid, bookOp, bookLocate, bookRefNum, bookBuySell, bookShares, bookPrice,
        input  ovfFlags, dropCnt
    );

    modport slave (
        input  addValid, addLocate, addRefNum, addBuySell, addShares, addPrice,
        input  delValid, delLocate, delRefNum, execValid, execLocate, execRefNum,
        input  bookReady, clrOvf,
        output bookValid, bookOp, bookLocate, bookRefNum, bookBuySell, bookShares, bookPrice,
        output ovfFlags, dropCnt
    );
endinterface

// File: rtl/itch_arb_fifo.sv
// rtl/itch_arb_fifo.sv - single-clock FIFO of {stamp, command} with a combinational head
module itch_arb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Push while full is only allowed together with a pop, so the write lands in the slot being freed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/itch_book_arbiter.sv
// rtl/itch_book_arbiter.sv - merges add/exec/del streams into one arrival-ordered book command stream
module itch_book_arbiter
    import itch_book_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_W      = 6,
    parameter int DROP_W     = 16
) (
    input logic                clk,
    input logic                rstN,
    itch_book_arbiter_if.slave bus
);
    localparam int EW = SEQ_W + CMD_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Source index 0=add, 1=exec, 2=del doubles as the same-cycle stamp order.
    logic [2:0]        strobe, accept, drop, full, empty, sel, pop;
    book_cmd_t         src_cmd [3];
    logic [SEQ_W-1:0]  stamp [3];
    logic [EW-1:0]     din [3];
    logic [EW-1:0]     head [3];
    logic [CW-1:0]     count [3];
    logic [SEQ_W-1:0]  seq;
    logic              load;
    book_cmd_t         sel_cmd, out_cmd;
    logic              out_valid;
    logic [2:0]        ovf;
    logic [DROP_W-1:0] drops;
    logic [DROP_W:0]   drop_sum;
    logic [1:0]        ndrop;
    logic              unused_count;

    assign strobe = {bus.delValid, bus.execValid, bus.addValid};

    always_comb begin
        src_cmd[0] = '{op: OP_ADD, locate: bus.addLocate, refNum: bus.addRefNum,
                       buySell: bus.addBuySell, shares: bus.addShares, price: bus.addPrice};
        src_cmd[1] = '{op: OP_EXEC, locate: bus.execLocate, refNum: bus.execRefNum,
                       buySell: 1'b0, shares: '0, price: '0};
        src_cmd[2] = '{op: OP_DEL, locate: bus.delLocate, refNum: bus.delRefNum,
                       buySell: 1'b0, shares: '0, price: '0};
    end

    always_comb begin
        stamp[0] = seq;
        stamp[1] = seq + SEQ_W'(accept[0]);
        stamp[2] = seq + SEQ_W'(accept[0]) + SEQ_W'(accept[1]);
    end

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        assign din[i] = {stamp[i], src_cmd[i]};
        itch_arb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
            .clk   (clk),
            .rstN  (rstN),
            .push  (accept[i]),
            .pop   (pop[i]),
            .din   (din[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i]),
            .count (count[i])
        );
    end

    // Occupancy is only needed for observation; arbitration works from full/empty.
    assign unused_count = ^{count[0], count[1], count[2]};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sel[i] = !empty[i];
            for (int j = 0; j < 3; j++) begin
                if (j != i && !empty[j] &&
                    !is_older(32'(head[i][EW-1 -: SEQ_W]), 32'(head[j][EW-1 -: SEQ_W]), SEQ_W))
                    sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        sel_cmd = book_cmd_t'(head[0][CMD_W-1:0]);
        if (sel[1]) sel_cmd = book_cmd_t'(head[1][CMD_W-1:0]);
        if (sel[2]) sel_cmd = book_cmd_t'(head[2][CMD_W-1:0]);
    end

    assign load   = (!out_valid || bus.bookReady) && (empty != 3'b111);
    assign pop    = load ? sel : 3'b000;
    assign accept = strobe & (~full | pop);
    assign drop   = strobe & ~accept;

    always_comb begin
        ndrop    = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
        drop_sum = (bus.clrOvf ? '0 : {1'b0, drops}) + (DROP_W+1)'(ndrop);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            seq       <= '0;
            out_valid <= 1'b0;
            out_cmd   <= '0;
            ovf       <= '0;
            drops     <= '0;
        end else begin
            seq <= seq + SEQ_W'(accept[0]) + SEQ_W'(accept[1]) + SEQ_W'(accept[2]);
            if (load) begin
                out_valid <= 1'b1;
                out_cmd   <= sel_cmd;
            end else if (bus.bookReady) begin
                out_valid <= 1'b0;
            end
            ovf   <= (bus.clrOvf ? 3'b000 : ovf) | {drop[1], drop[2], drop[0]};
            drops <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

    assign bus.bookValid   = out_valid;
    assign bus.bookOp      = out_cmd.op;
    assign bus.bookLocate  = out_cmd.locate;
    assign bus.bookRefNum  = out_cmd.refNum;
    assign bus.bookBuySell = out_cmd.buySell;
    assign bus.bookShares  = out_cmd.shares;
    assign bus.bookPrice   = out_cmd.price;
    assign bus.ovfFlags    = ovf;
    assign bus.dropCnt     = drops;

endmodule

// File: tb/tb_itch_book_arbiter.sv
// tb/tb_itch_book_arbiter.sv - self-checking bench for itch_book_arbiter
module tb_itch_book_arbiter;
    import itch_book_pkg::*;

    localparam int DEPTH  = 8;
    localparam int SEQ_W  = 6;
    localparam int DROP_W = 16;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    itch_book_arbiter_if #(.DROP_W(DROP_W)) bus ();

    itch_book_arbiter #(.FIFO_DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        op_t         src;
        logic [15:0] loc;
        logic [63:0] refn;
        logic        bs;
        logic [31:0] sh;
        logic [31:0] pr;
        logic        exp_bs;
        logic [31:0] exp_sh;
        logic [31:0] exp_pr;
    } vec_t;

    typedef struct {
        int unsigned arr;
        book_cmd_t   cmd;
    } ment_t;

    vec_t        tbl [4];
    ment_t       mq [3][$];
    logic        m_valid;
    book_cmd_t   m_cmd;
    logic [2:0]  m_flags;
    int          m_drops;
    int unsigned m_arr;
    int          fbit [3] = '{0, 2, 1};

    function automatic book_cmd_t mk(input op_t op, input logic [15:0] loc, input logic [63:0] r,
                                     input logic bs, input logic [31:0] sh, input logic [31:0] pr);
        book_cmd_t c;
        c.op = op; c.locate = loc; c.refNum = r; c.buySell = bs; c.shares = sh; c.price = pr;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.addValid = 0; bus.addLocate = '0; bus.addRefNum = '0; bus.addBuySell = 0;
        bus.addShares = '0; bus.addPrice = '0;
        bus.delValid = 0; bus.delLocate = '0; bus.delRefNum = '0;
        bus.execValid = 0; bus.execLocate = '0; bus.execRefNum = '0;
        bus.clrOvf = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_cmd(input string name, input book_cmd_t exp);
        book_cmd_t got;
        got.op = bus.bookOp; got.locate = bus.bookLocate; got.refNum = bus.bookRefNum;
        got.buySell = bus.bookBuySell; got.shares = bus.bookShares; got.price = bus.bookPrice;
        vectors++;
        if (bus.bookValid !== 1'b1 || got !== exp) begin
            miscompares++;
            $display("FAIL %s: valid=%b got %0h expected %0h", name, bus.bookValid, got, exp);
        end
    endtask

    task automatic set_add(input logic [63:0] r);
        bus.addValid = 1; bus.addLocate = 16'h0042; bus.addRefNum = r; bus.addBuySell = 1;
        bus.addShares = r[31:0]; bus.addPrice = 32'h1000;
    endtask
    task automatic set_del(input logic [63:0] r);
        bus.delValid = 1; bus.delLocate = 16'h0043; bus.delRefNum = r;
    endtask
    task automatic set_exec(input logic [63:0] r);
        bus.execValid = 1; bus.execLocate = 16'h0044; bus.execRefNum = r;
    endtask
    function automatic book_cmd_t e_add(input logic [63:0] r);
        return mk(OP_ADD, 16'h0042, r, 1'b1, r[31:0], 32'h1000);
    endfunction
    function automatic book_cmd_t e_del(input logic [63:0] r);
        return mk(OP_DEL, 16'h0043, r, 1'b0, 32'd0, 32'd0);
    endfunction
    function automatic book_cmd_t e_exec(input logic [63:0] r);
        return mk(OP_EXEC, 16'h0044, r, 1'b0, 32'd0, 32'd0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{OP_ADD,  16'h0012, 64'h1, 1'b1, 32'd100, 32'h2710, 1'b1, 32'd100, 32'h2710};
        tbl[1] = '{OP_DEL,  16'h0034, 64'hDEAD_BEEF_0000_0002, 1'b1, 32'd55, 32'd77, 1'b0, 32'd0, 32'd0};
        tbl[2] = '{OP_EXEC, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   1'b0, 32'd0, 32'd0};
        tbl[3] = '{OP_ADD,  16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0,
                   1'b0, 32'hFFFF_FFFF, 32'h0};

        idle();
        bus.bookReady = 1;
        tick(); tick();
        chk("rst_valid", bus.bookValid, 0);
        chk("rst_ref", bus.bookRefNum, 0);
        chk("rst_ovf", bus.ovfFlags, 0);
        chk("rst_drop", bus.dropCnt, 0);
        rstN = 1;
        tick();

        // Single-message vectors: latency, payload routing, one-cycle pulse.
        for (int v = 0; v < 4; v++) begin
            idle();
            bus.addLocate = tbl[v].loc; bus.addRefNum = tbl[v].refn; bus.addBuySell = tbl[v].bs;
            bus.addShares = tbl[v].sh; bus.addPrice = tbl[v].pr;
            case (tbl[v].src)
                OP_ADD:  bus.addValid = 1;
                OP_DEL:  begin bus.delValid = 1; bus.delLocate = tbl[v].loc; bus.delRefNum = tbl[v].refn; end
                default: begin bus.execValid = 1; bus.execLocate = tbl[v].loc; bus.execRefNum = tbl[v].refn; end
            endcase
            tick();
            idle();
            chk("tbl_latency", bus.bookValid, 0);
            tick();
            chk_cmd("tbl_cmd", mk(tbl[v].src, tbl[v].loc, tbl[v].refn, tbl[v].exp_bs, tbl[v].exp_sh, tbl[v].exp_pr));
            tick();
            chk("tbl_pulse", bus.bookValid, 0);
        end

        // Same-cycle arrivals come out add, exec, del.
        set_add(5); set_exec(6); set_del(7);
        tick(); idle();
        tick(); chk_cmd("same_add", e_add(5));
        tick(); chk_cmd("same_exec", e_exec(6));
        tick(); chk_cmd("same_del", e_del(7));
        tick(); chk("same_end", bus.bookValid, 0);

        // Stall hold then ordered release.
        bus.bookReady = 0;
        set_del(64'hA); tick(); idle();
        set_add(64'hB); tick(); idle();
        for (int k = 0; k < 10; k++) begin
            chk_cmd("stall_hold", e_del(64'hA));
            tick();
        end
        bus.bookReady = 1;
        chk_cmd("stall_rel_del", e_del(64'hA));
        tick(); chk_cmd("stall_rel_add", e_add(64'hB));
        tick(); chk("stall_end", bus.bookValid, 0);

        // Output register occupied by a del, then 9 adds against a depth-8 FIFO.
        bus.bookReady = 0;
        set_del(64'hD0); tick(); idle();
        for (int k = 1; k <= 9; k++) begin
            set_add(64'(k)); tick();
        end
        idle();
        chk("ovf_flags", bus.ovfFlags, 3'b001);
        chk("ovf_drop", bus.dropCnt, 1);
        chk_cmd("ovf_head", e_del(64'hD0));
        bus.bookReady = 1;
        for (int k = 1; k <= 8; k++) begin
            tick(); chk_cmd("ovf_drain", e_add(64'(k)));
        end
        tick(); chk("ovf_empty", bus.bookValid, 0);
        bus.clrOvf = 1; tick(); bus.clrOvf = 0;
        chk("clr_flags", bus.ovfFlags, 0);
        chk("clr_drop", bus.dropCnt, 0);

        // Reset while stalled with a FIFO entry behind the held command.
        bus.bookReady = 0;
        set_add(64'h77); tick(); idle();
        set_add(64'h78); tick(); idle();
        chk_cmd("prereset_hold", e_add(64'h77));
        #2 rstN = 0;
        #1 chk("reset_async", bus.bookValid, 0);
        tick(); tick();
        rstN = 1;
        tick(); chk("postreset_empty0", bus.bookValid, 0);
        tick(); chk("postreset_empty1", bus.bookValid, 0);
        bus.bookReady = 1;
        set_add(64'h99); tick(); idle();
        chk("postreset_lat", bus.bookValid, 0);
        tick(); chk_cmd("postreset_add", e_add(64'h99));
        tick(); chk("postreset_end", bus.bookValid, 0);

        // Randomized traffic against an arrival-order reference model.
        m_valid = 0; m_cmd = '0; m_flags = 0; m_drops = 0; m_arr = 0;
        for (int cyc = 0; cyc < 240; cyc++) begin
            logic [2:0]  stb;
            logic        rdy;
            book_cmd_t   rc [3];
            int          sz [3];
            bit          popped [3];
            bit          mload;
            int          pick;
            int          nd;
            stb = '0;
            rdy = 1;
            if (cyc < 200) begin
                stb[cyc % 3] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) stb[$urandom_range(0, 2)] = 1'b1;
                rdy = ($urandom_range(0, 3) != 0);
            end
            rc[0] = mk(OP_ADD, 16'($urandom), {$urandom, $urandom}, 1'($urandom), $urandom, $urandom);
            rc[1] = mk(OP_EXEC, 16'($urandom), {$urandom, $urandom}, 1'b0, 32'd0, 32'd0);
            rc[2] = mk(OP_DEL, 16'($urandom), {$urandom, $urandom}, 1'b0, 32'd0, 32'd0);
            bus.addValid = stb[0]; bus.addLocate = rc[0].locate; bus.addRefNum = rc[0].refNum;
            bus.addBuySell = rc[0].buySell; bus.addShares = rc[0].shares; bus.addPrice = rc[0].price;
            bus.execValid = stb[1]; bus.execLocate = rc[1].locate; bus.execRefNum = rc[1].refNum;
            bus.delValid = stb[2]; bus.delLocate = rc[2].locate; bus.delRefNum = rc[2].refNum;
            bus.bookReady = rdy;

            for (int i = 0; i < 3; i++) begin
                sz[i] = mq[i].size();
                popped[i] = 0;
            end
            mload = (!m_valid || rdy) && (sz[0] + sz[1] + sz[2] > 0);
            if (mload) begin
                pick = -1;
                for (int i = 0; i < 3; i++)
                    if (sz[i] > 0 && (pick < 0 || mq[i][0].arr < mq[pick][0].arr)) pick = i;
                m_cmd = mq[pick][0].cmd;
                m_valid = 1;
                void'(mq[pick].pop_front());
                popped[pick] = 1;
            end else if (rdy) begin
                m_valid = 0;
            end
            nd = 0;
            for (int i = 0; i < 3; i++) begin
                if (stb[i]) begin
                    if (sz[i] < DEPTH || popped[i]) begin
                        mq[i].push_back('{m_arr, rc[i]});
                        m_arr++;
                    end else begin
                        nd++;
                        m_flags[fbit[i]] = 1'b1;
                    end
                end
            end
            m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;

            tick();
            chk("rnd_valid", bus.bookValid, m_valid);
            if (m_valid) chk_cmd("rnd_cmd", m_cmd);
            chk("rnd_ovf", bus.ovfFlags, m_flags);
            chk("rnd_drop", bus.dropCnt, 64'(m_drops));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
